// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic registered FIFO with flush; DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign rdata   = mem_q[rd_ptr_q];
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch initiator: owns the PC, queues {pc, instr} pairs toward decode, and parks in FAULT on a bad address.
module fetch_sequencer #(
  parameter int unsigned     XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_pc,
  input  logic [31:0]     imem_instr,
  input  logic            imem_inv_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  import fetch_pkg::*;

  localparam int unsigned ENTRY_W = XLEN + INSTR_W;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic               deq, space, take, push, go_fault;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] head;

  assign deq      = out_valid & out_ready;
  assign space    = ~fifo_full | deq;
  // Redirect pre-empts any fetch decision, so a fetch is only taken when it is absent.
  assign take     = (state_q == RUN) & fetch_en & space & ~redirect_valid;
  assign push     = take & ~imem_inv_addr;
  assign go_fault = take & imem_inv_addr;

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    fault_pc_d = fault_pc_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = RUN;
    end else if (go_fault) begin
      state_d    = FAULT;
      fault_pc_d = pc_q;
    end else if (push) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .pop   (deq),
    .wdata ({pc_q, imem_instr}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign imem_pc   = pc_q;
  assign out_valid = ~fifo_empty;
  assign out_pc    = head[INSTR_W +: XLEN];
  assign out_instr = head[INSTR_W-1:0];
  assign fault     = (state_q == FAULT);
  assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;

  localparam int unsigned     XLEN     = 64;
  localparam int unsigned     DEPTH    = 2;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fetch_en = 1'b0;
  logic [XLEN-1:0] imem_pc;
  logic [31:0]     imem_instr;
  logic            imem_inv_addr;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            fault;
  logic [XLEN-1:0] fault_pc;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [XLEN+31:0] q[$];
  logic [XLEN-1:0]  m_pc;
  logic             m_fault;
  logic [XLEN-1:0]  m_fault_pc;

  fetch_sequencer #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .imem_inv_addr  (imem_inv_addr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    case (a)
      64'h0:   mem_word = 32'h0055_0533;
      64'h4:   mem_word = 32'h40b5_0533;
      64'h8:   mem_word = 32'h00c5_0533;
      default: mem_word = a[31:0] ^ 32'h1357_9bdf;
    endcase
  endfunction

  function automatic logic mem_inv(input logic [XLEN-1:0] a);
    mem_inv = (a[1:0] != 2'b00) || (a[XLEN-1:2] > 62'd1023);
  endfunction

  always_comb begin
    imem_instr    = mem_word(imem_pc);
    imem_inv_addr = mem_inv(imem_pc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc       = RESET_PC;
    m_fault    = 1'b0;
    m_fault_pc = '0;
  endtask

  // One clock of the specified behaviour, evaluated on the pre-edge state.
  task automatic model_step(input logic fe, input logic rv, input logic [XLEN-1:0] rpc,
                            input logic ordy);
    bit vld, dq, spc;
    vld = (q.size() > 0);
    dq  = vld && ordy;
    spc = (q.size() < DEPTH) || dq;
    if (rv) begin
      q.delete();
      m_pc    = rpc;
      m_fault = 1'b0;
    end else begin
      if (dq) void'(q.pop_front());
      if (!m_fault && fe && spc) begin
        if (mem_inv(m_pc)) begin
          m_fault    = 1'b1;
          m_fault_pc = m_pc;
        end else begin
          q.push_back({m_pc, mem_word(m_pc)});
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("imem_pc", imem_pc, m_pc);
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("fault", 64'(fault), 64'(m_fault));
    check("fault_pc", fault_pc, m_fault_pc);
    if (q.size() > 0) begin
      check("out_pc", out_pc, q[0][XLEN+31:32]);
      check("out_instr", 64'(out_instr), 64'(q[0][31:0]));
    end
  endtask

  task automatic step(input logic fe, input logic rv, input logic [XLEN-1:0] rpc,
                      input logic ordy);
    @(negedge clk);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ordy;
    #1;
    check_outputs();
    model_step(fe, rv, rpc, ordy);
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [XLEN-1:0] rand_target();
    logic [XLEN-1:0] t;
    case ($urandom % 5)
      0:       t = 64'($urandom_range(0, 1023)) << 2;
      1:       t = 64'($urandom_range(1015, 1023)) << 2;
      2:       t = (64'($urandom_range(0, 1023)) << 2) | 64'($urandom_range(1, 3));
      3:       t = 64'h1000;
      default: t = {$urandom, $urandom};
    endcase
    return t;
  endfunction

  initial begin
    do_reset();
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_pc", imem_pc, RESET_PC);
    check("rst_fault_pc", fault_pc, 64'd0);

    // streaming fetch, one per cycle
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);

    // backpressure, then drain in order
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);

    // redirect out of range, then recover by redirect
    step(1'b1, 1'b1, 64'h1000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, 64'h4, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);

    // redirect coinciding with a dequeue from a full FIFO
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 64'h40, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);

    // run off the end of memory with an entry still queued, then async reset
    step(1'b1, 1'b1, 64'd4088, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_fault", 64'(fault), 64'd0);
    check("arst_pc", imem_pc, RESET_PC);
    check("arst_fault_pc", fault_pc, 64'd0);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      logic fe, rv, rdy;
      fe  = ($urandom % 10) < 8;
      rv  = ($urandom % 12) == 0;
      rdy = ($urandom % 10) < 6;
      step(fe, rv, rand_target(), rdy);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Initiator side of the instruction-memory fetch interface: owns the PC and drives it to the combinational instruction memory.
- Captures the returned instruction word or invalid-address flag each cycle.
- Queues {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Sits between the branch/redirect logic and the decode stage.

Parameters:
- XLEN, 64, PC width in bits.
- RESET_PC, 64'h0, PC value loaded on reset.
- DEPTH, 2, FIFO entries; must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_en  input  1  when high, fetch is permitted this cycle.
- imem_pc  output  XLEN  address to instruction memory; equals the PC register.
- imem_instr  input  32  instruction word from memory; same-cycle (combinational) response.
- imem_inv_addr  input  1  memory flags imem_pc misaligned or out of range.
- redirect_valid  input  1  branch/jump redirect request.
- redirect_pc  input  XLEN  redirect target.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  decode accepts the head.
- out_pc  output  XLEN  PC of the head entry.
- out_instr  output  32  instruction of the head entry.
- fault  output  1  sequencer is in FAULT.
- fault_pc  output  XLEN  PC that raised the fault.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; FIFO empty with rd_ptr=wr_ptr=count=0; state=RUN.
  - fault=0; fault_pc=0; out_valid=0.
- State machine: RUN and FAULT.
- Definitions:
  - deq = out_valid & out_ready.
  - space = (count<DEPTH) | deq.
- RUN, each cycle, with no redirect:
  - fetch_en=1, space=1, imem_inv_addr=0: enqueue {pc, imem_instr}; pc<=pc+4, wrapping modulo 2^XLEN.
  - fetch_en=1, space=1, imem_inv_addr=1: no enqueue; go to FAULT; fault_pc<=pc; pc holds.
  - fetch_en=0 or space=0: pc holds, no enqueue. imem_inv_addr is ignored in this case (no fetch is taken).
- FAULT:
  - fault=1; pc holds; no enqueue.
  - The FIFO keeps draining normally.
  - The only exits are redirect or reset.
- Redirect (redirect_valid=1) has highest priority, in any state:
  - Flush the FIFO (count<=0, pointers<=0); any simultaneous deq is discarded.
  - pc<=redirect_pc; state<=RUN; fault<=0.
  - Nothing is enqueued that cycle.
  - A misaligned redirect_pc is accepted; memory flags it next cycle and the sequencer enters FAULT.
- FIFO:
  - Registered storage; head outputs are driven from storage, not from imem.
  - Fetch-to-out_valid latency is 1 cycle.
  - Enqueue and dequeue in the same cycle leave count unchanged; a full FIFO with deq=1 still accepts an enqueue.
  - Pointers wrap modulo DEPTH.
  - out_pc/out_instr are don't-care when out_valid=0.
- Throughput: 1 instruction/cycle sustained with out_ready held high.
- fault_pc holds its value until the next fault or reset; it is not cleared by redirect.

Decomposition:
- Shared package fetch_pkg:
  - XLEN, INSTR_W=32, PC_STEP=4.
  - State enum {RUN, FAULT}.
  - Packed struct fetch_entry_t {pc, instr}.
- One sub-module, sync_fifo: generic DEPTH×width FIFO with push/pop/full/empty/flush. The same FIFO is reusable for the later decode queue.
- The sequencer FSM and PC logic stay in fetch_sequencer.

Test Plan (bench memory: 0x0=00550533, 0x4=40b50533, 0x8=00c50533; invalid for PC[1:0]!=0 or PC[63:2]>1023):
- Reset, then fetch_en=1, out_ready=1 -> out_valid rises 1 cycle later; out_pc/out_instr = 0/00550533, 4/40b50533, 8/00c50533 on consecutive cycles.
- out_ready=0 for 5 cycles -> FIFO fills with pc 0 and 4; pc holds at 8. Then raise out_ready -> entries 0, 4, 8 emerge in order with no loss or duplication.
- Redirect to 0x1000 -> FIFO flushed; next cycle fault=1, fault_pc=0x1000, out_valid=0, pc stays 0x1000.
- While in FAULT, redirect to 0x4 -> fault=0, fetch resumes; out_pc sequence 4, 8.
- redirect_valid and deq asserted in the same cycle with FIFO full -> count=0 next cycle; pc=redirect_pc; no stale entry appears on out.
- Drop rst_n asynchronously mid-stream -> outputs immediately return to reset values (out_valid=0, fault=0); pc=RESET_PC after release.
